rf_wb_arbiter: RTL and testbench

Writeback arbiter and register scoreboard for the 32×32 register file. It shares the register file's single write port among `N_REQ` writeback sources, such as ALU, load/store unit and multiply/divide unit, using a round-robin valid/ready handshake. It drives the write port from a one-entry output register. A 32-bit busy scoreboard lets the issue stage detect RAW and WAW hazards against in-flight writebacks.

---
 rtl/rf_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Writeback arbiter and busy-register scoreboard for a 32x32
//            register file with a single write port. N_REQ writeback sources
//            are arbitrated round-robin. The winner is registered into a
//            one-entry output stage that drives the write port. A 32-bit busy
//            scoreboard tracks destinations that have been issued but not yet
//            written back, so the issue stage can detect RAW and WAW hazards.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          : clock, rising edge
//   reset_ni       : asynchronous reset, active low
//   req_valid_i    : per-requester writeback pending
//   req_ready_o    : one-hot grant (accept when valid & ready)
//   req_addr_i     : destination register of requester i at [5i+4:5i]
//   req_data_i     : writeback data of requester i at [32i+31:32i]
//   rf_we_o        : register file write enable
//   rf_waddr_o     : register file write address
//   rf_wdata_o     : register file write data
//   iss_valid_i    : issue stage wants to dispatch a writer of iss_waddr_i
//   iss_waddr_i    : destination register of the issuing instruction
//   iss_ready_o    : dispatch accepted, destination marked busy
//   q_addr1_i/2_i  : source registers being queried
//   q_busy1_o/2_o  : queried register has a writeback outstanding
// ============================================================================
module rf_wb_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [5*N_REQ-1:0]  req_addr_i,
  input  logic [32*N_REQ-1:0] req_data_i,
  output logic                rf_we_o,
  output logic [4:0]          rf_waddr_o,
  output logic [31:0]         rf_wdata_o,
  input  logic                iss_valid_i,
  input  logic [4:0]          iss_waddr_i,
  output logic                iss_ready_o,
  input  logic [4:0]          q_addr1_i,
  input  logic [4:0]          q_addr2_i,
  output logic                q_busy1_o,
  output logic                q_busy2_o
);

  localparam int LW = $clog2(N_REQ);
  localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);

  // Round-robin pointer: index of the most recently accepted requester.
  logic [LW-1:0] last_q, last_d;

  // Output stage.
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  // Scoreboard.
  logic [31:0] busy_q, busy_d;

  // Arbitration results.
  logic [N_REQ-1:0] grant;
  logic [LW-1:0]    gidx;
  logic             accept;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;
  int               idx;

  // Scan last+1, last+2, ... modulo N_REQ; the first valid requester wins.
  // Because the grant only ever lands on a valid requester, any grant is
  // also an accept (the handshake completes in the same cycle).
  always_comb begin
    grant  = '0;
    gidx   = last_q;
    accept = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!accept && req_valid_i[idx]) begin
        grant[idx] = 1'b1;
        gidx       = LW'(idx);
        accept     = 1'b1;
      end
    end
  end

  assign req_ready_o = grant;
  assign sel_addr    = req_addr_i[5*int'(gidx) +: 5];
  assign sel_data    = req_data_i[32*int'(gidx) +: 32];

  always_comb begin
    last_d  = last_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      last_d  = gidx;
      // Writes to r0 are accepted but never reach the register file.
      we_d    = (sel_addr != 5'd0);
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
  end

  // busy_q[0] is always 0, so an issue to r0 is never stalled and never
  // marks anything busy.
  assign iss_ready_o = iss_valid_i & ~busy_q[iss_waddr_i];

  // Clear is applied before set so a same-edge issue to the register being
  // written back keeps it busy: the new producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (accept) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (iss_ready_o) begin
      busy_d[iss_waddr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q  <= LAST_RST;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 32'd0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;

  // No bypass of a same-cycle clear: the write-through register file read
  // covers the cycle after acceptance.
  assign q_busy1_o = busy_q[q_addr1_i];
  assign q_busy2_o = busy_q[q_addr2_i];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter with N_REQ = 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int N = 3;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          iss_valid;
  logic [4:0]    iss_waddr;
  logic          iss_ready;
  logic [4:0]    q_addr1, q_addr2;
  logic          q_busy1, q_busy2;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter #(.N_REQ(N)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .iss_valid_i (iss_valid),
    .iss_waddr_i (iss_waddr),
    .iss_ready_o (iss_ready),
    .q_addr1_i   (q_addr1),
    .q_addr2_i   (q_addr2),
    .q_busy1_o   (q_busy1),
    .q_busy2_o   (q_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_waddr = 5'd0;
    q_addr1   = 5'd0;
    q_addr2   = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_in_reset: got %b expected 0", rf_we); end
    tick();
    tick();
    reset_n = 1'b1;
    q_addr1 = 5'd5;
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    n_checks++;
    if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %h expected 00", rf_waddr); end
    n_checks++;
    if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00000000", rf_wdata); end
    n_checks++;
    if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    n_checks++;
    if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_qbusy5: got %b expected 0", q_busy1); end
    n_checks++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iss_ready: got %b expected 0", iss_ready); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_grant [6];
    logic [4:0]  exp_addr  [6];
    logic [31:0] exp_data  [6];
    exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_addr  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    exp_data  = '{32'hA, 32'hB, 32'hC, 32'hA, 32'hB, 32'hC};
    do_reset();
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC, 32'hB, 32'hA};
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (req_ready !== exp_grant[c])
        begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_grant[c]); end
      tick();
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== exp_addr[c] || rf_wdata !== exp_data[c])
        begin n_fail++; $display("FAIL rr_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                                 c, rf_we, rf_waddr, rf_wdata, exp_addr[c], exp_data[c]); end
      #1;
    end
    req_valid = '0;
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'hC)
      begin n_fail++; $display("FAIL rr_drain_hold: got we=%b addr=%0d data=%h expected we=0 addr=3 data=0000000c",
                               rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_raw();
    do_reset();
    iss_valid = 1'b1;
    iss_waddr = 5'd7;
    q_addr1   = 5'd7;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL raw_iss_ready: got %b expected 1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    #1;
    n_checks++;
    if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL raw_busy_set: got %b expected 1", q_busy1); end
    req_addr[9:5]   = 5'd7;
    req_data[63:32] = 32'h1234;
    req_valid       = 3'b010;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL raw_grant: got %b expected 010", req_ready); end
    n_checks++;
    if (q_busy1 !== 1'b1) begin n_fail++; $display("FAIL raw_no_bypass: got %b expected 1", q_busy1); end
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL raw_busy_clear: got %b expected 0", q_busy1); end
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234)
      begin n_fail++; $display("FAIL raw_write: got we=%b addr=%0d data=%h expected we=1 addr=7 data=00001234",
                               rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_waw();
    do_reset();
    iss_valid = 1'b1;
    iss_waddr = 5'd9;
    q_addr2   = 5'd9;
    tick();
    n_checks++;
    if (q_busy2 !== 1'b1) begin n_fail++; $display("FAIL waw_busy_set: got %b expected 1", q_busy2); end
    n_checks++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b expected 0", iss_ready); end
    tick();
    n_checks++;
    if (q_busy2 !== 1'b1) begin n_fail++; $display("FAIL waw_stall_hold: got %b expected 1", q_busy2); end
    // Drain r9 with the issue withheld.
    iss_valid      = 1'b0;
    req_addr[4:0]  = 5'd9;
    req_data[31:0] = 32'h99;
    req_valid      = 3'b001;
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (q_busy2 !== 1'b0) begin n_fail++; $display("FAIL waw_cleared: got %b expected 0", q_busy2); end
    // Simultaneous writeback of r9 and fresh issue to r9: set wins.
    req_valid = 3'b001;
    iss_valid = 1'b1;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL waw_same_edge_iss: got %b expected 1", iss_ready); end
    tick();
    req_valid = '0;
    iss_valid = 1'b0;
    #1;
    n_checks++;
    if (q_busy2 !== 1'b1) begin n_fail++; $display("FAIL waw_set_wins: got %b expected 1", q_busy2); end
  endtask

  task automatic test_r0();
    do_reset();
    req_addr[14:10]  = 5'd0;
    req_data[95:64]  = 32'hFFFF_FFFF;
    req_valid        = 3'b100;
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin n_fail++; $display("FAIL r0_grant: got %b expected 100", req_ready); end
    tick();
    req_valid = '0;
    n_checks++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'hFFFF_FFFF)
      begin n_fail++; $display("FAIL r0_no_write: got we=%b data=%h expected we=0 data=ffffffff", rf_we, rf_wdata); end
    iss_valid = 1'b1;
    iss_waddr = 5'd0;
    q_addr1   = 5'd0;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL r0_iss_ready: got %b expected 1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    n_checks++;
    if (q_busy1 !== 1'b0) begin n_fail++; $display("FAIL r0_not_busy: got %b expected 0", q_busy1); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    iss_valid = 1'b1;
    iss_waddr = 5'd4;
    tick();
    iss_waddr = 5'd5;
    q_addr1   = 5'd4;
    q_addr2   = 5'd5;
    tick();
    iss_valid = 1'b0;
    n_checks++;
    if (q_busy1 !== 1'b1 || q_busy2 !== 1'b1)
      begin n_fail++; $display("FAIL mid_busy_set: got %b%b expected 11", q_busy1, q_busy2); end
    req_addr[4:0]  = 5'd4;
    req_data[31:0] = 32'h4444;
    req_valid      = 3'b001;
    tick();
    req_valid = '0;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4)
      begin n_fail++; $display("FAIL mid_write: got we=%b addr=%0d expected we=1 addr=4", rf_we, rf_waddr); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      begin n_fail++; $display("FAIL mid_out_cleared: got we=%b addr=%0d data=%h expected 0/0/0",
                               rf_we, rf_waddr, rf_wdata); end
    n_checks++;
    if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0)
      begin n_fail++; $display("FAIL mid_busy_cleared: got %b%b expected 00", q_busy1, q_busy2); end
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_after_release: got %b expected 0", rf_we); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_raw();
    test_waw();
    test_r0();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
